// File: rtl/jk_exc_driver_if.sv
// Command handshake bundle for jk_exc_driver: the requester drives an op with its
// operands and the driver answers with cmd_ready.
interface jk_exc_driver_if #(
  parameter int W  = 4,
  parameter int CW = 8
);
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_op;
  logic [W-1:0]  cmd_data;
  logic [CW-1:0] cmd_cnt;

  modport master (output cmd_valid, cmd_op, cmd_data, cmd_cnt, input cmd_ready);
  modport slave  (input cmd_valid, cmd_op, cmd_data, cmd_cnt, output cmd_ready);
endinterface

// File: rtl/jk_exc_driver.sv
// J/K excitation driver for an external bank of W JK flip-flops, tracking the bank in q_shadow.
// Define JK_TOGGLE_EXC_EN to drive every changing bit with J=K=1 instead of set/reset encoding.
module jk_exc_driver #(
  parameter int W  = 4,
  parameter int CW = 8
) (
  input  logic           clk,
  input  logic           rest_n,
  jk_exc_driver_if.slave cmd,
  output logic [W-1:0]   j,
  output logic [W-1:0]   k,
  output logic [W-1:0]   q_shadow,
  output logic           busy,
  output logic           done
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_LOAD = 2'b01;
  localparam logic [1:0] OP_UP   = 2'b10;
  localparam logic [1:0] OP_DOWN = 2'b11;

  state_t        state;
  logic [1:0]    op;
  logic [W-1:0]  target;
  logic [CW-1:0] remaining;
  logic [W-1:0]  nxt;
  logic [W-1:0]  diff;

  always_comb begin
    nxt = q_shadow;
    case (op)
      OP_LOAD: nxt = target;
      OP_UP:   nxt = q_shadow + W'(1);
      OP_DOWN: nxt = q_shadow - W'(1);
      default: nxt = q_shadow;
    endcase
  end

  // Only bits that actually change get any drive; everything else holds.
  assign diff = (state == RUN) ? (q_shadow ^ nxt) : '0;

`ifdef JK_TOGGLE_EXC_EN
  assign j = diff;
  assign k = diff;
`else
  assign j = diff & nxt;
  assign k = diff & q_shadow;
`endif

  assign cmd.cmd_ready = (state == IDLE);
  assign busy          = (state == RUN);

  always_ff @(posedge clk or negedge rest_n) begin
    if (!rest_n) begin
      state     <= IDLE;
      op        <= OP_NOP;
      target    <= '0;
      remaining <= '0;
      q_shadow  <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd.cmd_valid) begin
            op <= cmd.cmd_op;
            case (cmd.cmd_op)
              OP_NOP: done <= 1'b1;
              OP_LOAD: begin
                target    <= cmd.cmd_data;
                remaining <= CW'(1);
                state     <= RUN;
              end
              default: begin
                // A zero-length count completes immediately without touching the bank.
                if (cmd.cmd_cnt == '0) begin
                  done <= 1'b1;
                end else begin
                  remaining <= cmd.cmd_cnt;
                  state     <= RUN;
                end
              end
            endcase
          end
        end
        RUN: begin
          q_shadow  <= nxt;
          remaining <= remaining - CW'(1);
          if (remaining == CW'(1)) begin
            state <= IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
